// File: rtl/pe_pkg.sv
// Shared definitions for the SIMD processing element: default widths, the opcode set,
// and the operand vector type.
package pe_pkg;

  localparam int DEF_OPCODE_LEN  = 4;
  localparam int DEF_PC_WIDTH    = 12;
  localparam int DEF_INST_LEN    = 12;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_PE_ELEMENTS = 4;
  localparam int DEF_DRAM_DEPTH  = 256;

  typedef enum logic [DEF_OPCODE_LEN-1:0] {
    OP_NOP     = 4'h0,
    OP_ADD     = 4'h1,
    OP_STOP    = 4'h8,
    OP_FETCH_A = 4'h9,
    OP_FETCH_B = 4'hA
  } opcode_e;

  typedef logic [DEF_PE_ELEMENTS-1:0][DEF_DATA_WIDTH-1:0] vec_t;

endpackage

// File: rtl/pe_fetch.sv
// Fetch/decode front end of a SIMD PE: PC walk, opcode decode, and two independent
// vector read channels (RAM A / RAM B) whose returned data is latched one edge after issue.
module pe_fetch
  import pe_pkg::*;
#(
  parameter int OPCODE_LEN  = DEF_OPCODE_LEN,
  parameter int PC_WIDTH    = DEF_PC_WIDTH,
  parameter int INST_LEN    = DEF_INST_LEN,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int PE_ELEMENTS = DEF_PE_ELEMENTS,
  parameter int DRAM_DEPTH  = DEF_DRAM_DEPTH
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  valid,
  output logic [OPCODE_LEN-1:0]                 opcode,
  output logic [PC_WIDTH-1:0]                   inst_read_addr,
  input  logic [INST_LEN-1:0]                   inst_read_data,
  output logic [$clog2(DRAM_DEPTH)-1:0]         ram_a_read_addr,
  input  logic [PE_ELEMENTS-1:0][DATA_WIDTH-1:0] ram_a_read_data,
  output logic                                  ram_a_rd_en,
  output logic [$clog2(DRAM_DEPTH)-1:0]         ram_b_read_addr,
  input  logic [PE_ELEMENTS-1:0][DATA_WIDTH-1:0] ram_b_read_data,
  output logic                                  ram_b_rd_en,
  output logic [PE_ELEMENTS-1:0][DATA_WIDTH-1:0] data_a,
  output logic [PE_ELEMENTS-1:0][DATA_WIDTH-1:0] data_b
);

  localparam int DRAM_ADDR_WIDTH = $clog2(DRAM_DEPTH);
  localparam logic [OPCODE_LEN-1:0] C_STOP    = OPCODE_LEN'(OP_STOP);
  localparam logic [OPCODE_LEN-1:0] C_FETCH_A = OPCODE_LEN'(OP_FETCH_A);
  localparam logic [OPCODE_LEN-1:0] C_FETCH_B = OPCODE_LEN'(OP_FETCH_B);

  logic [PC_WIDTH-1:0]                   r_pc;
  logic [OPCODE_LEN-1:0]                 r_opcode;
  logic                                  r_halt;
  logic [DRAM_ADDR_WIDTH-1:0]            r_a_addr;
  logic [DRAM_ADDR_WIDTH-1:0]            r_b_addr;
  logic                                  r_a_rd_en;
  logic                                  r_b_rd_en;
  logic [PE_ELEMENTS-1:0][DATA_WIDTH-1:0] r_data_a;
  logic [PE_ELEMENTS-1:0][DATA_WIDTH-1:0] r_data_b;

  logic [OPCODE_LEN-1:0]                 w_opc;
  logic [INST_LEN-OPCODE_LEN-1:0]        w_field;
  logic [DRAM_ADDR_WIDTH-1:0]            w_addr;
  logic                                  w_adv;
  logic                                  w_is_a;
  logic                                  w_is_b;

  always_comb begin
    w_opc   = inst_read_data[OPCODE_LEN-1:0];
    w_field = inst_read_data[INST_LEN-1:OPCODE_LEN];
    w_addr  = DRAM_ADDR_WIDTH'(w_field);
    w_adv   = valid && !r_halt;
    w_is_a  = w_adv && (w_opc == C_FETCH_A);
    w_is_b  = w_adv && (w_opc == C_FETCH_B);
  end

  // STOP is consumed (opcode updates) but the PC stays on it; halt is only left via reset.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_pc     <= '0;
      r_opcode <= '0;
      r_halt   <= 1'b0;
    end else if (w_adv) begin
      r_opcode <= w_opc;
      if (w_opc == C_STOP) begin
        r_halt <= 1'b1;
      end else begin
        r_pc <= r_pc + PC_WIDTH'(1);
      end
    end
  end

  // Read channel A: strobe for one cycle per fetch, capture the returned vector on the next edge.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_a_addr  <= '0;
      r_a_rd_en <= 1'b0;
      r_data_a  <= '0;
    end else begin
      if (r_a_rd_en) r_data_a <= ram_a_read_data;
      if (!r_halt)   r_a_rd_en <= w_is_a;
      if (w_is_a)    r_a_addr  <= w_addr;
    end
  end

  // Read channel B mirrors A on its own port, so A and B fetches overlap freely.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_b_addr  <= '0;
      r_b_rd_en <= 1'b0;
      r_data_b  <= '0;
    end else begin
      if (r_b_rd_en) r_data_b <= ram_b_read_data;
      if (!r_halt)   r_b_rd_en <= w_is_b;
      if (w_is_b)    r_b_addr  <= w_addr;
    end
  end

  assign opcode          = r_opcode;
  assign inst_read_addr  = r_pc;
  assign ram_a_read_addr = r_a_addr;
  assign ram_a_rd_en     = r_a_rd_en;
  assign ram_b_read_addr = r_b_addr;
  assign ram_b_rd_en     = r_b_rd_en;
  assign data_a          = r_data_a;
  assign data_b          = r_data_b;

endmodule

// File: tb/tb_pe_fetch.sv
// Self-checking bench for pe_fetch: behavioural model compared every cycle, plus
// directed hand-computed checks for reset, fetch, STOP/halt, in-flight reset and PC wrap.
module tb_pe_fetch;
  import pe_pkg::*;

  logic        clk;
  logic        rstn;
  logic        valid;
  logic [3:0]  opcode;
  logic [11:0] inst_read_addr;
  logic [11:0] inst_read_data;
  logic [7:0]  ram_a_read_addr;
  vec_t        ram_a_read_data;
  logic        ram_a_rd_en;
  logic [7:0]  ram_b_read_addr;
  vec_t        ram_b_read_data;
  logic        ram_b_rd_en;
  vec_t        data_a;
  vec_t        data_b;

  logic [11:0] imem  [0:4095];
  vec_t        ram_a [0:255];
  vec_t        ram_b [0:255];

  localparam vec_t VA = {32'hA1A1_0001, 32'hA2A2_0002, 32'hA3A3_0003, 32'hA4A4_0004};
  localparam vec_t VB = {32'hB1B1_0001, 32'hB2B2_0002, 32'hB3B3_0003, 32'hB4B4_0004};

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  pe_fetch dut (
    .clk(clk), .rstn(rstn), .valid(valid),
    .opcode(opcode),
    .inst_read_addr(inst_read_addr), .inst_read_data(inst_read_data),
    .ram_a_read_addr(ram_a_read_addr), .ram_a_read_data(ram_a_read_data), .ram_a_rd_en(ram_a_rd_en),
    .ram_b_read_addr(ram_b_read_addr), .ram_b_read_data(ram_b_read_data), .ram_b_rd_en(ram_b_rd_en),
    .data_a(data_a), .data_b(data_b)
  );

  assign inst_read_data  = imem[inst_read_addr];
  assign ram_a_read_data = ram_a[ram_a_read_addr];
  assign ram_b_read_data = ram_b[ram_b_read_addr];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a read consumed at one edge shows up in the operand one edge later.
  logic [11:0] m_pc;
  logic [3:0]  m_op;
  logic [7:0]  m_aaddr, m_baddr;
  logic        m_apend, m_bpend, m_halt;
  vec_t        m_da, m_db;

  initial begin
    m_pc = 0; m_op = 0; m_aaddr = 0; m_baddr = 0;
    m_apend = 0; m_bpend = 0; m_halt = 0; m_da = '0; m_db = '0;
  end

  always @(posedge clk or posedge rstn) begin
    if (rstn) begin
      m_pc = 0; m_op = 0; m_aaddr = 0; m_baddr = 0;
      m_apend = 0; m_bpend = 0; m_halt = 0; m_da = '0; m_db = '0;
    end else begin
      logic [11:0] inst;
      if (m_apend) m_da = ram_a[m_aaddr];
      if (m_bpend) m_db = ram_b[m_baddr];
      if (!m_halt && valid) begin
        inst    = imem[m_pc];
        m_op    = inst[3:0];
        m_apend = (inst[3:0] == 4'h9);
        m_bpend = (inst[3:0] == 4'hA);
        if (m_apend) m_aaddr = inst[11:4];
        if (m_bpend) m_baddr = inst[11:4];
        if (inst[3:0] == 4'h8) m_halt = 1;
        else m_pc = 12'((int'(m_pc) + 1) % 4096);
      end else if (!m_halt) begin
        m_apend = 0;
        m_bpend = 0;
      end
    end
  end

  always begin
    @(negedge clk);
    #1;
    if (cmp_on) begin
      check("m_pc",     128'(inst_read_addr),  128'(m_pc));
      check("m_opcode", 128'(opcode),          128'(m_op));
      check("m_a_addr", 128'(ram_a_read_addr), 128'(m_aaddr));
      check("m_a_en",   128'(ram_a_rd_en),     128'(m_apend));
      check("m_b_addr", 128'(ram_b_read_addr), 128'(m_baddr));
      check("m_b_en",   128'(ram_b_rd_en),     128'(m_bpend));
      check("m_data_a", data_a,                m_da);
      check("m_data_b", data_b,                m_db);
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_pc"},   128'(inst_read_addr), 128'(0));
    check({tag, "_op"},   128'(opcode), 128'(0));
    check({tag, "_aad"},  128'(ram_a_read_addr), 128'(0));
    check({tag, "_bad"},  128'(ram_b_read_addr), 128'(0));
    check({tag, "_aen"},  128'(ram_a_rd_en), 128'(0));
    check({tag, "_ben"},  128'(ram_b_rd_en), 128'(0));
    check({tag, "_da"},   data_a, 128'(0));
    check({tag, "_db"},   data_b, 128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    clk = 0; rstn = 1; valid = 0;
    for (int i = 0; i < 4096; i++) imem[i] = 12'h000;
    for (int i = 0; i < 256; i++) begin
      ram_a[i] = {4{32'hAA00_0000 | 32'(i)}};
      ram_b[i] = {4{32'hBB00_0000 | 32'(i)}};
    end
    imem[0] = 12'h000; imem[1] = 12'h019; imem[2] = 12'h01A;
    imem[3] = 12'h001; imem[4] = 12'h008;
    ram_a[1] = VA;
    ram_b[1] = VB;

    // Test 1: reset, then idle with valid low
    repeat (2) @(negedge clk);
    cmp_on = 1'b1;
    #1 check_all_zero("t1_rst");
    @(negedge clk) rstn = 0;
    repeat (3) @(negedge clk);
    #1;
    check("t1_pc_idle", 128'(inst_read_addr), 128'(0));
    check("t1_aen_idle", 128'(ram_a_rd_en), 128'(0));
    check("t1_ben_idle", 128'(ram_b_rd_en), 128'(0));

    // Test 2: NOP then FETCH_A
    @(negedge clk) valid = 1;
    repeat (2) @(negedge clk);
    valid = 0;
    #1;
    check("t2_op", 128'(opcode), 128'(4'h9));
    check("t2_pc", 128'(inst_read_addr), 128'(2));
    check("t2_aaddr", 128'(ram_a_read_addr), 128'(1));
    check("t2_aen", 128'(ram_a_rd_en), 128'(1));
    @(negedge clk);
    #1;
    check("t2_data_a", data_a, VA);
    check("t2_aen_off", 128'(ram_a_rd_en), 128'(0));

    // Test 3: FETCH_B, ADD, STOP
    @(negedge clk) valid = 1;
    @(negedge clk);
    #1;
    check("t3_op_fb", 128'(opcode), 128'(4'hA));
    check("t3_ben", 128'(ram_b_rd_en), 128'(1));
    check("t3_baddr", 128'(ram_b_read_addr), 128'(1));
    @(negedge clk);
    #1;
    check("t3_op_add", 128'(opcode), 128'(4'h1));
    check("t3_ben_off", 128'(ram_b_rd_en), 128'(0));
    check("t3_data_b", data_b, VB);
    repeat (3) @(negedge clk);
    #1;
    check("t3_op_stop", 128'(opcode), 128'(4'h8));
    check("t3_pc_frozen", 128'(inst_read_addr), 128'(4));

    // Test 4: halted with valid high, then reset and resume
    repeat (10) @(negedge clk);
    #1;
    check("t4_pc", 128'(inst_read_addr), 128'(4));
    check("t4_op", 128'(opcode), 128'(4'h8));
    check("t4_da", data_a, VA);
    check("t4_db", data_b, VB);
    @(negedge clk);
    valid = 0; rstn = 1;
    #1 check_all_zero("t4_rst");
    @(negedge clk);
    rstn = 0; valid = 1;
    @(negedge clk);
    #1;
    check("t4_resume_pc", 128'(inst_read_addr), 128'(1));
    check("t4_resume_op", 128'(opcode), 128'(0));

    // Test 5: reset right after FETCH_A issue discards the in-flight read
    @(negedge clk);
    #1 check("t5_aen_issued", 128'(ram_a_rd_en), 128'(1));
    @(negedge clk);
    valid = 0; rstn = 1;
    #1 check_all_zero("t5_rst");
    @(negedge clk) rstn = 0;
    repeat (2) @(negedge clk);
    #1 check("t5_data_a", data_a, 128'(0));

    // Test 6: all-NOP program, PC wraps from 0xFFF to 0
    @(negedge clk);
    for (int i = 0; i < 8; i++) imem[i] = 12'h000;
    rstn = 1;
    @(negedge clk);
    rstn = 0; valid = 1;
    repeat (4095) @(negedge clk);
    #1 check("t6_pc_top", 128'(inst_read_addr), 128'(12'hFFF));
    @(negedge clk);
    valid = 0;
    #1;
    check("t6_pc_wrap", 128'(inst_read_addr), 128'(0));
    check("t6_op", 128'(opcode), 128'(0));

    @(negedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
